// File: rtl/ysyx_22041211_ifu_fetch.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22041211_ifu_fetch
// Brief    : Multi-cycle, non-pipelined instruction fetch unit. It owns the PC
//            and fetches one instruction over an AXI4-lite read port. It hands
//            the instruction to decode and waits for write-back to retire it
//            and supply the next PC. A bus error or a misaligned next PC halts
//            the unit until reset.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22041211_ifu_fetch #(
  parameter int                  DATA_LEN = 32,
  parameter int                  ADDR_LEN = 32,
  parameter logic [ADDR_LEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                clk,
  input  logic                rst,
  // AXI4-lite read address channel
  output logic [ADDR_LEN-1:0] addr_r_addr_o,
  output logic                addr_r_valid_o,
  input  logic                addr_r_ready_i,
  // AXI4-lite read data channel
  input  logic [DATA_LEN-1:0] r_data_i,
  input  logic [1:0]          r_resp_i,
  input  logic                r_valid_i,
  output logic                r_ready_o,
  // decode interface
  output logic [DATA_LEN-1:0] inst_o,
  output logic [ADDR_LEN-1:0] pc_o,
  output logic                ifu_valid_o,
  input  logic                idu_ready_i,
  // write-back interface
  input  logic                wb_valid_i,
  input  logic [ADDR_LEN-1:0] npc_i,
  // status
  output logic                fetch_err_o,
  output logic [1:0]          err_cause_o,
  output logic [31:0]         retire_cnt_o
);

  typedef enum logic [2:0] {
    FETCH_ADDR = 3'd0,
    WAIT_DATA  = 3'd1,
    HAND_OFF   = 3'd2,
    WAIT_WB    = 3'd3,
    HALT       = 3'd4
  } state_t;

  localparam logic [1:0] c_resp_okay      = 2'b00;
  localparam logic [1:0] c_cause_bus      = 2'b01;
  localparam logic [1:0] c_cause_misalign = 2'b10;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_LEN-1:0]   r_pc;
  logic [DATA_LEN-1:0]   r_inst;
  logic [31:0]           r_retire_cnt;
  logic                  r_fetch_err;
  logic [1:0]            r_err_cause;

  logic                  w_addr_valid;
  logic                  w_r_ready;
  logic                  w_ifu_valid;
  logic                  w_inst_load;
  logic                  w_bus_err;
  logic                  w_retire;
  logic                  w_pc_load;
  logic                  w_misalign;

  // Next-state decode and per-state handshake strobes / datapath enables.
  always_comb begin
    w_state_nxt  = r_state;
    w_addr_valid = 1'b0;
    w_r_ready    = 1'b0;
    w_ifu_valid  = 1'b0;
    w_inst_load  = 1'b0;
    w_bus_err    = 1'b0;
    w_retire     = 1'b0;
    w_pc_load    = 1'b0;
    w_misalign   = 1'b0;
    case (r_state)
      FETCH_ADDR: begin
        w_addr_valid = 1'b1;
        if (addr_r_ready_i) begin
          w_state_nxt = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        w_r_ready = 1'b1;
        if (r_valid_i) begin
          if (r_resp_i == c_resp_okay) begin
            w_inst_load = 1'b1;
            w_state_nxt = HAND_OFF;
          end else begin
            w_bus_err   = 1'b1;
            w_state_nxt = HALT;
          end
        end
      end
      HAND_OFF: begin
        w_ifu_valid = 1'b1;
        if (idu_ready_i) begin
          w_state_nxt = WAIT_WB;
        end
      end
      WAIT_WB: begin
        if (wb_valid_i) begin
          w_retire = 1'b1;
          if (npc_i[1:0] == 2'b00) begin
            w_pc_load   = 1'b1;
            w_state_nxt = FETCH_ADDR;
          end else begin
            w_misalign  = 1'b1;
            w_state_nxt = HALT;
          end
        end
      end
      HALT: begin
        w_state_nxt = HALT;
      end
      // Corrupted encodings park the unit; the recorded cause is left alone.
      default: begin
        w_state_nxt = HALT;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH_ADDR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // PC, instruction latch, retire counter and sticky error status.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_inst       <= '0;
      r_retire_cnt <= 32'd0;
      r_fetch_err  <= 1'b0;
      r_err_cause  <= 2'b00;
    end else begin
      if (w_inst_load) begin
        r_inst <= r_data_i;
      end
      if (w_pc_load) begin
        r_pc <= npc_i;
      end
      if (w_retire) begin
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end
      if (w_bus_err) begin
        r_fetch_err <= 1'b1;
        r_err_cause <= c_cause_bus;
      end
      if (w_misalign) begin
        r_fetch_err <= 1'b1;
        r_err_cause <= c_cause_misalign;
      end
    end
  end

  // Handshake outputs are forced low for the whole reset cycle, even though
  // the state register only resets at the clock edge.
  assign addr_r_valid_o = w_addr_valid & ~rst;
  assign r_ready_o      = w_r_ready & ~rst;
  assign ifu_valid_o    = w_ifu_valid & ~rst;

  assign addr_r_addr_o  = r_pc;
  assign pc_o           = r_pc;
  assign inst_o         = r_inst;
  assign fetch_err_o    = r_fetch_err;
  assign err_cause_o    = r_err_cause;
  assign retire_cnt_o   = r_retire_cnt;

endmodule
`default_nettype wire
